// File: rtl/pa_soc_uart_rx.sv
// UART receiver (8N1, LSB first) with a small RX FIFO and a CR/SR/RXD register window.
// The line is sampled mid-bit by a counter that is re-aligned on every start bit.
`timescale 1ns/1ps

`ifndef CPU_FREQ_HZ
`define CPU_FREQ_HZ 1843200
`endif

module pa_soc_uart_rx #(
  parameter int unsigned UART_BAUD  = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  addr_i,
  input  logic        data_rd_i,
  input  logic        data_we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        pad_rxd
);

  localparam int unsigned BitCycles  = `CPU_FREQ_HZ / UART_BAUD;
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);

  localparam logic [31:0]   BitLast  = 32'(BitCycles - 1);
  localparam logic [31:0]   HalfLast = 32'(HalfCycles - 1);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  localparam logic [7:0] AddrCr  = 8'h00;
  localparam logic [7:0] AddrSr  = 8'h04;
  localparam logic [7:0] AddrRxd = 8'h10;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge-detect register
  // ---------------------------------------------------------------------------
  logic rxd_meta_q, rxd_s_q, rxd_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_q      <= 1'b1;
    end else begin
      rxd_meta_q <= pad_rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_q      <= rxd_s_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Control register
  // ---------------------------------------------------------------------------
  logic [31:0] cr_q;
  logic        rx_en;

  assign rx_en = cr_q[0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cr_q <= 32'h1;
    end else if (data_we_i && (addr_i == AddrCr)) begin
      cr_q <= data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_done;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_en && rxd_q && !rxd_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          if (!rxd_s_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d             = '0;
          shift_d[bit_idx_q] = rxd_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          state_d   = StIdle;
          stop_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Disabling the receiver abandons any frame in progress.
    if (!rx_en && (state_q != StIdle)) begin
      state_d   = StIdle;
      cnt_d     = '0;
      stop_done = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            fifo_full, fifo_empty;
  logic            push_req, push, pop;
  logic            ovr_set, ferr_set;

  assign fifo_full  = (count_q == DepthCnt);
  assign fifo_empty = (count_q == '0);

  assign push_req = stop_done & rxd_s_q;
  assign ferr_set = stop_done & ~rxd_s_q;
  assign pop      = data_rd_i & (addr_i == AddrRxd) & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~fifo_full | pop);
  assign ovr_set  = push_req & fifo_full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags (W1C, hardware set has priority over a clear)
  // ---------------------------------------------------------------------------
  logic ovr_q, ovr_d;
  logic ferr_q, ferr_d;
  logic sr_we;

  assign sr_we  = data_we_i & (addr_i == AddrSr);
  assign ovr_d  = ovr_set  | (ovr_q  & ~(sr_we & data_i[1]));
  assign ferr_d = ferr_set | (ferr_q & ~(sr_we & data_i[2]));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    data_o = '0;
    if (data_rd_i) begin
      case (addr_i)
        AddrCr:  data_o = cr_q;
        AddrSr:  data_o = {28'b0, fifo_full, ferr_q, ovr_q, ~fifo_empty};
        AddrRxd: data_o = fifo_empty ? 32'b0 : {24'b0, mem_q[rd_ptr_q]};
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pa_soc_uart_rx.sv
// Self-checking bench for pa_soc_uart_rx: serial frames in, scoreboard of expected bytes
// and status flags, compared on register reads.
`timescale 1ns/1ps

`ifndef CPU_FREQ_HZ
`define CPU_FREQ_HZ 1843200
`endif

module tb_pa_soc_uart_rx;

  localparam int unsigned Baud  = 115200;
  localparam int unsigned Depth = 4;
  localparam int unsigned P     = `CPU_FREQ_HZ / Baud;
  localparam int unsigned H     = P / 2;

  localparam logic [7:0] ACr  = 8'h00;
  localparam logic [7:0] ASr  = 8'h04;
  localparam logic [7:0] ARxd = 8'h10;

  logic        clk_i;
  logic        rst_n_i;
  logic [7:0]  addr_i;
  logic        data_rd_i;
  logic        data_we_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        pad_rxd;

  pa_soc_uart_rx #(
    .UART_BAUD  (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .addr_i    (addr_i),
    .data_rd_i (data_rd_i),
    .data_we_i (data_we_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .pad_rxd   (pad_rxd)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard / model state
  logic [7:0] exp_q [$];
  bit         exp_ovr;
  bit         exp_ferr;
  int         n_checks;
  int         n_pass;

  function automatic logic [31:0] exp_sr();
    logic full, nempty;
    full   = (exp_q.size() == Depth);
    nempty = (exp_q.size() != 0);
    return {28'b0, full, exp_ferr, exp_ovr, nempty};
  endfunction

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk_i);
    #1;
    addr_i    = a;
    data_rd_i = 1'b1;
    @(negedge clk_i);
    d = data_o;
    @(posedge clk_i);
    #1;
    data_rd_i = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] v);
    @(posedge clk_i);
    #1;
    addr_i    = a;
    data_i    = v;
    data_we_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  // Drives one 8N1 frame; 'record' updates the scoreboard with the expected outcome.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit record);
    @(posedge clk_i);
    #1 pad_rxd = 1'b0;
    repeat (P) @(posedge clk_i);
    for (int i = 0; i < 8; i++) begin
      #1 pad_rxd = b[i];
      repeat (P) @(posedge clk_i);
    end
    #1 pad_rxd = stop;
    repeat (P) @(posedge clk_i);
    #1 pad_rxd = 1'b1;
    if (record) begin
      if (!stop) exp_ferr = 1'b1;
      else if (exp_q.size() < Depth) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    addr_i = ACr;
    if (data_o !== 32'h0) begin
      $display("FAIL reset_idle_bus: got %h want %h", data_o, 32'h0);
    end else n_pass++;
    n_checks++;
    bus_read(ACr, d);
    if (d !== 32'h1) begin
      $display("FAIL reset_cr: got %h want %h", d, 32'h1);
    end else n_pass++;
    n_checks++;
    bus_read(ASr, d);
    if (d !== 32'h0) begin
      $display("FAIL reset_sr: got %h want %h", d, 32'h0);
    end else n_pass++;
    n_checks++;
    bus_read(ARxd, d);
    if (d !== 32'h0) begin
      $display("FAIL reset_rxd: got %h want %h", d, 32'h0);
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_registers();
    logic [31:0] d;
    bus_write(ACr, 32'hABCD_0001);
    bus_read(ACr, d);
    if (d !== 32'hABCD_0001) begin
      $display("FAIL cr_rw: got %h want %h", d, 32'hABCD_0001);
    end else n_pass++;
    n_checks++;
    bus_write(ARxd, 32'hFFFF_FFFF);
    bus_write(8'h08, 32'hFFFF_FFFF);
    bus_read(ASr, d);
    if (d !== exp_sr()) begin
      $display("FAIL sr_after_ignored_writes: got %h want %h", d, exp_sr());
    end else n_pass++;
    n_checks++;
    bus_read(8'h08, d);
    if (d !== 32'h0) begin
      $display("FAIL unmapped_read: got %h want %h", d, 32'h0);
    end else n_pass++;
    n_checks++;
    bus_write(ACr, 32'h1);
  endtask

  task automatic test_single();
    logic [31:0] d;
    logic [7:0]  e;
    send_byte(8'h55, 1'b1, 1'b1);
    idle(4);
    bus_read(ASr, d);
    if (d !== 32'h1 || d !== exp_sr()) begin
      $display("FAIL single_sr: got %h want %h", d, 32'h1);
    end else n_pass++;
    n_checks++;
    bus_read(ARxd, d);
    e = exp_q.pop_front();
    if (d !== {24'b0, e}) begin
      $display("FAIL single_rxd: got %h want %h", d, {24'b0, e});
    end else n_pass++;
    n_checks++;
    bus_read(ASr, d);
    if (d !== exp_sr()) begin
      $display("FAIL single_sr_after: got %h want %h", d, exp_sr());
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [31:0] e;
    logic [7:0]  bytes [4];
    bytes[0] = 8'hA3; bytes[1] = 8'h01; bytes[2] = 8'hFF; bytes[3] = 8'h80;
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1, 1'b1);
    idle(4);
    bus_read(ASr, d);
    if (d !== 32'h9 || d !== exp_sr()) begin
      $display("FAIL full_sr: got %h want %h", d, 32'h9);
    end else n_pass++;
    n_checks++;
    send_byte(8'h12, 1'b1, 1'b1);
    idle(4);
    bus_read(ASr, d);
    if (d !== 32'hB || d !== exp_sr()) begin
      $display("FAIL overrun_sr: got %h want %h", d, 32'hB);
    end else n_pass++;
    n_checks++;
    for (int i = 0; i < 5; i++) begin
      bus_read(ARxd, d);
      e = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'h0;
      if (d !== e) begin
        $display("FAIL overrun_read%0d: got %h want %h", i, d, e);
      end else n_pass++;
      n_checks++;
    end
    bus_write(ASr, 32'h2);
    exp_ovr = 1'b0;
    bus_read(ASr, d);
    if (d !== exp_sr()) begin
      $display("FAIL overrun_clear: got %h want %h", d, exp_sr());
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    send_byte(8'h3C, 1'b0, 1'b1);
    idle(4);
    bus_read(ASr, d);
    if (d !== 32'h4 || d !== exp_sr()) begin
      $display("FAIL frame_sr: got %h want %h", d, 32'h4);
    end else n_pass++;
    n_checks++;
    bus_read(ARxd, d);
    if (d !== 32'h0) begin
      $display("FAIL frame_rxd_empty: got %h want %h", d, 32'h0);
    end else n_pass++;
    n_checks++;
    bus_write(ASr, 32'h4);
    exp_ferr = 1'b0;
    bus_read(ASr, d);
    if (d !== 32'h0 || d !== exp_sr()) begin
      $display("FAIL frame_clear: got %h want %h", d, 32'h0);
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic [7:0]  e;
    @(posedge clk_i);
    #1 pad_rxd = 1'b0;
    repeat (H / 2) @(posedge clk_i);
    #1 pad_rxd = 1'b1;
    idle(2 * P);
    bus_read(ASr, d);
    if (d !== 32'h0) begin
      $display("FAIL glitch_sr: got %h want %h", d, 32'h0);
    end else n_pass++;
    n_checks++;
    send_byte(8'h7E, 1'b1, 1'b1);
    idle(4);
    bus_read(ARxd, d);
    e = exp_q.pop_front();
    if (d !== {24'b0, e}) begin
      $display("FAIL glitch_next_byte: got %h want %h", d, {24'b0, e});
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_disable();
    logic [31:0] d;
    logic [7:0]  e;
    fork
      send_byte(8'hA5, 1'b1, 1'b0);
      begin
        // Lands in the middle of data bit 3.
        repeat (3 + H + 3 * P + P / 2) @(posedge clk_i);
        bus_write(ACr, 32'h0);
      end
    join
    idle(4);
    bus_write(ACr, 32'h1);
    idle(4);
    bus_read(ASr, d);
    if (d !== exp_sr()) begin
      $display("FAIL disable_sr: got %h want %h", d, exp_sr());
    end else n_pass++;
    n_checks++;
    send_byte(8'h42, 1'b1, 1'b1);
    idle(4);
    bus_read(ARxd, d);
    e = exp_q.pop_front();
    if (d !== {24'b0, e}) begin
      $display("FAIL disable_rxd: got %h want %h", d, {24'b0, e});
    end else n_pass++;
    n_checks++;
    bus_read(ASr, d);
    if (d !== exp_sr()) begin
      $display("FAIL disable_sr_after: got %h want %h", d, exp_sr());
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] e;
    logic [7:0]  bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1, 1'b1);
    idle(4);
    bus_read(ASr, d);
    if (d !== 32'h9) begin
      $display("FAIL b2b_full: got %h want %h", d, 32'h9);
    end else n_pass++;
    n_checks++;
    fork
      send_byte(8'h55, 1'b1, 1'b1);
      begin
        // Pop edge coincides with the stop-bit sample edge (3 + H + 9P after launch).
        repeat (2 + H + 9 * P) @(posedge clk_i);
        bus_read(ARxd, d);
        e = {24'b0, exp_q.pop_front()};
        if (d !== e) begin
          $display("FAIL b2b_pop_head: got %h want %h", d, e);
        end else n_pass++;
        n_checks++;
      end
    join
    idle(4);
    bus_read(ASr, d);
    if (d !== 32'h9 || d !== exp_sr()) begin
      $display("FAIL b2b_sr: got %h want %h", d, 32'h9);
    end else n_pass++;
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      bus_read(ARxd, d);
      e = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'h0;
      if (d !== e) begin
        $display("FAIL b2b_order%0d: got %h want %h", i, d, e);
      end else n_pass++;
      n_checks++;
    end
    bus_read(ASr, d);
    if (d !== 32'h0) begin
      $display("FAIL b2b_drained: got %h want %h", d, 32'h0);
    end else n_pass++;
    n_checks++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    exp_ovr   = 1'b0;
    exp_ferr  = 1'b0;
    rst_n_i   = 1'b0;
    pad_rxd   = 1'b1;
    addr_i    = '0;
    data_rd_i = 1'b0;
    data_we_i = 1'b0;
    data_i    = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    test_reset();
    test_registers();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_disable();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
